// File: rtl/seq_mult_if.sv
// ----------------------------------------------------------------------------
// seq_mult_if : request/result bundle for the sequential 32x32 multiplier.
//
// Signals
//   start         requester -> multiplier   begin a multiply (sampled in IDLE)
//   multiplicand  requester -> multiplier   operand A, 32 bits
//   multiplier    requester -> multiplier   operand B, 32 bits
//   busy          multiplier -> requester   high while RUN or DONE
//   done          multiplier -> requester   one-cycle completion pulse
//   product       multiplier -> requester   registered 64-bit result
//
// Modports: master = requester (ALU control), slave = multiplier.
// ----------------------------------------------------------------------------
interface seq_mult_if;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mult_32.sv
// ----------------------------------------------------------------------------
// seq_mult_32 : multi-cycle unsigned 32x32 -> 64 shift-add multiplier built
// around the 32-bit ripple-carry adder (add_func). One adder pass per cycle;
// the adder carry-out becomes the top bit of the right-shifted {hi,lo} pair.
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, priority over everything
//   bus   slave modport of seq_mult_if (start/operands in, busy/done/product out)
//
// Parameters
//   WIDTH  operand width, must be 32 (the adder is 32-bit)
//   CNT_W  iteration counter width, must hold 32
//
// Optional build macro
//   SEQ_MULT_EARLY_DONE_EN : finish as soon as no multiplier bits remain,
//   aligning the partial product with one barrel shift. Undefined -> fixed
//   32-iteration latency and no barrel shifter.
// ----------------------------------------------------------------------------

// 32-bit ripple-carry adder; o_overflow is the carry-out.
module add_func (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [31:0] o_sum,
    output logic        o_overflow
);
    logic [32:0] w_c;

    assign w_c[0] = 1'b0;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign o_sum[i]  = i_x[i] ^ i_y[i] ^ w_c[i];
        assign w_c[i+1]  = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
    end

    assign o_overflow = w_c[32];
endmodule

module seq_mult_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst,
    seq_mult_if.slave bus
);
    if (WIDTH != 32) begin : g_bad_width
        $error("seq_mult_32: WIDTH must be 32 to match add_func");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]       r_hi, w_hi_nxt;
    logic [WIDTH-1:0]       r_lo, w_lo_nxt;
    logic [CNT_W-1:0]       r_count, w_count_nxt;
    logic [2*WIDTH-1:0]     r_product, w_product_nxt;

    logic [WIDTH-1:0]       w_y;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_carry;
    logic [2*WIDTH-1:0]     w_shift;

    // Add the multiplicand only when the current multiplier bit is set.
    assign w_y = r_lo[0] ? r_mcand : '0;

    add_func u_add (
        .i_x        (r_hi),
        .i_y        (w_y),
        .o_sum      (w_sum),
        .o_overflow (w_carry)
    );

    // 65-bit {carry,sum,lo[31:1]} shifted right by one; the lsb of lo falls off.
    assign w_shift = {w_carry, w_sum, r_lo[WIDTH-1:1]};

`ifdef SEQ_MULT_EARLY_DONE_EN
    // lo[WIDTH-1-k:0] are the multiplier bits still to be processed.
    logic [WIDTH-1:0]   w_mask;
    logic               w_early;
    logic [CNT_W-1:0]   w_rsh;
    logic [2*WIDTH-1:0] w_early_prod;

    assign w_mask       = {WIDTH{1'b1}} >> r_count;
    assign w_early      = ((r_lo & w_mask) == '0);
    assign w_rsh        = CNT_W'(WIDTH) - r_count;
    assign w_early_prod = {r_hi, r_lo} >> w_rsh;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_count_nxt   = r_count;
        w_product_nxt = r_product;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_mcand_nxt = bus.multiplicand;
                    w_lo_nxt    = bus.multiplier;
                    w_hi_nxt    = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
`ifdef SEQ_MULT_EARLY_DONE_EN
                if (w_early) begin
                    w_product_nxt = w_early_prod;
                    w_state_nxt   = S_DONE;
                end else
`endif
                begin
                    w_hi_nxt    = w_shift[2*WIDTH-1:WIDTH];
                    w_lo_nxt    = w_shift[WIDTH-1:0];
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == CNT_W'(WIDTH-1)) begin
                        w_product_nxt = w_shift;
                        w_state_nxt   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_count   <= w_count_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.product = r_product;
endmodule

// File: tb/tb_seq_mult_32.sv
// ----------------------------------------------------------------------------
// tb_seq_mult_32 : scoreboard bench for seq_mult_32. Expected product and
// latency are queued when an operation is launched and compared on done.
// ----------------------------------------------------------------------------
module tb_seq_mult_32;
    logic clk;
    logic rst;

    seq_mult_if bus ();

    seq_mult_32 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    logic [63:0] exp_q[$];
    int          lat_q[$];
    logic [63:0] prev_prod;

`ifdef SEQ_MULT_EARLY_DONE_EN
    localparam int RST_AT = 1;
`else
    localparam int RST_AT = 10;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef SEQ_MULT_EARLY_DONE_EN
        int h;
        h = -1;
        for (int i = 0; i < 32; i++) if (b[i]) h = i;
        return (h + 2 > 32) ? 32 : h + 2;
`else
        return 32;
`endif
    endfunction

    // Launch one multiply; optionally pulse a stray start with other operands
    // at RUN cycle pulse_at. Checks latency, product, done width, busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at);
        int   cnt;
        bit   got;
        logic [63:0] e;
        int          el;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        exp_q.push_back(64'(a) * 64'(b));
        lat_q.push_back(exp_lat(b));
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'd2;
        cnt = 0;
        got = 1'b0;
        while (cnt < 100 && !got) begin
            @(posedge clk);
            cnt++;
            #1;
            bus.start = (cnt == pulse_at);
            if (bus.done) got = 1'b1;
            else if (cnt == 2) chk("prod_hold", bus.product, prev_prod);
        end
        bus.start = 1'b0;
        if (!got) begin
            chk("done_timeout", 64'd0, 64'd1);
        end else begin
            e  = exp_q.pop_front();
            el = lat_q.pop_front();
            chk("latency", 64'(cnt), 64'(el));
            chk("product", bus.product, e);
            chk("busy_in_done", 64'(bus.busy), 64'd1);
            prev_prod = e;
            @(posedge clk);
            #1;
            chk("done_pulse", 64'(bus.done), 64'd0);
            chk("busy_after", 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        n_vec            = 0;
        n_err            = 0;
        prev_prod        = '0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_prod", bus.product, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(32'h1234_5678, 32'd0, -1);
        run_op(32'd0, 32'hDEAD_BEEF, -1);

        // Stray start during RUN must be ignored.
        run_op(32'd7, 32'd6, 1);
        chk("prod_42", bus.product, 64'h2A);
        watch_no_done("no_second_done", 40);

        // Reset in the middle of RUN aborts without a done pulse.
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = 32'h8000_0000;
        bus.multiplier   = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (RST_AT) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_prod", bus.product, 64'd0);
        prev_prod = '0;
        watch_no_done("abort_no_done", 40);
        run_op(32'h8000_0000, 32'd2, -1);
        chk("prod_2p32", bus.product, 64'h0000_0001_0000_0000);

        run_op(32'd1, 32'h8000_0000, -1);
        chk("prod_msb", bus.product, 64'h0000_0000_8000_0000);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
